// File: rtl/bl_pkg.sv
// Shared constants and TX state encoding for the zone backlight SPI path.
// Holds the zone count, zone index width, checksum width and FSM states.
package bl_pkg;

  localparam int ZONES   = 360;
  localparam int ZONE_AW = 9;
  localparam int CSUM_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_LATCH
  } tx_st_e;

endpackage

// File: rtl/bl_zone_ram.sv
// Ping-pong zone buffer: 2 banks x ZONES bytes, addressed by {bank, idx}.
// Ports: clk_i; write we_i/wr_bank_i/wr_idx_i/wr_data_i; registered read rd_*.
module bl_zone_ram
  import bl_pkg::*;
(
  input  logic               clk_i,
  input  logic               we_i,
  input  logic               wr_bank_i,
  input  logic [ZONE_AW-1:0] wr_idx_i,
  input  logic [7:0]         wr_data_i,
  input  logic               rd_bank_i,
  input  logic [ZONE_AW-1:0] rd_idx_i,
  output logic [7:0]         rd_data_o
);

  logic [7:0] mem_q [2][ZONES];
  logic [7:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wr_bank_i][wr_idx_i] <= wr_data_i;
    rd_data_q <= mem_q[rd_bank_i][rd_idx_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/bl_zone_spi_tx.sv
// Collects zone bytes into a ping-pong buffer and shifts each complete
// frame out over SPI mode 0 (MSB first), then pulses led_latch.
// In: i_pix_clk, rst_n, flag_done, buf_360_flatted[7:0], r_Vsync_0.
// Out: spi_sclk/mosi/cs_n, led_latch, tx_busy, err_short, err_overflow,
//      tx_overrun, frame_cnt[15:0].
// Macro BL_SPI_CHECKSUM_EN appends an XOR checksum byte to each frame.
module bl_zone_spi_tx
  import bl_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int LATCH_CYCLES = 8
) (
  input  logic        i_pix_clk,
  input  logic        rst_n,
  input  logic        flag_done,
  input  logic [7:0]  buf_360_flatted,
  input  logic        r_Vsync_0,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  output logic        led_latch,
  output logic        tx_busy,
  output logic        err_short,
  output logic        err_overflow,
  output logic        tx_overrun,
  output logic [15:0] frame_cnt
);

`ifdef BL_SPI_CHECKSUM_EN
  localparam int NBYTES = ZONES + 1;
`else
  localparam int NBYTES = ZONES;
`endif
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(LATCH_CYCLES - 1);
  localparam logic [ZONE_AW-1:0] ZMAX = ZONE_AW'(ZONES);
  localparam logic [ZONE_AW-1:0] ZLAST = ZONE_AW'(ZONES - 1);
  localparam logic [ZONE_AW-1:0] BLAST = ZONE_AW'(NBYTES - 1);

  tx_st_e st_q, st_d;

  logic               vs_q;
  logic [ZONE_AW-1:0] wr_idx_q, wr_idx_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic               pend_q, pend_d;
  logic               eshort_q, eshort_d;
  logic               eovf_q, eovf_d;
  logic               eovr_q, eovr_d;

  logic               vs_rise, wr_en, full, swap;
  logic [ZONE_AW-1:0] idx_nxt;

  logic [DIV_W-1:0]   div_q, div_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [2:0]         bit_q, bit_d;
  logic [ZONE_AW-1:0] byte_q, byte_d;
  logic [6:0]         sh_q, sh_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               cs_n_q, cs_n_d;
  logic               latch_q, latch_d;
  logic               busy_q, busy_d;
  logic [15:0]        fcnt_q, fcnt_d;

  logic               div_end, bit_end, last_bit;
  logic [ZONE_AW-1:0] rd_idx;
  logic [7:0]         rd_data, nxt_byte;

`ifdef BL_SPI_CHECKSUM_EN
  logic [CSUM_W-1:0]  csum_q, csum_d;
`endif

  // Byte k+1 is always addressed while byte k shifts, so it is ready
  // at the byte boundary with no gap.
  assign rd_idx = (st_q == ST_SHIFT && byte_q < ZLAST)
                ? byte_q + 1'b1 : '0;

  bl_zone_ram u_ram (
    .clk_i     (i_pix_clk),
    .we_i      (wr_en),
    .wr_bank_i (wr_bank_q),
    .wr_idx_i  (wr_idx_q),
    .wr_data_i (buf_360_flatted),
    .rd_bank_i (rd_bank_q),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rd_data)
  );

  // Write side; a same-cycle write counts before the boundary check.
  always_comb begin
    vs_rise   = r_Vsync_0 & ~vs_q;
    wr_en     = flag_done & (wr_idx_q != ZMAX);
    idx_nxt   = wr_en ? wr_idx_q + 1'b1 : wr_idx_q;
    full      = (idx_nxt == ZMAX);
    swap      = vs_rise & full & (st_q == ST_IDLE) & ~pend_q;
    wr_idx_d  = vs_rise ? '0 : idx_nxt;
    wr_bank_d = swap ? ~wr_bank_q : wr_bank_q;
    rd_bank_d = swap ? wr_bank_q : rd_bank_q;
    pend_d    = swap | (pend_q & (st_q != ST_IDLE));
    eshort_d  = vs_rise & ~full;
    eovf_d    = flag_done & ~wr_en;
    eovr_d    = vs_rise & full & ~swap;
  end

  assign div_end  = (div_q == DIV_MAX);
  assign bit_end  = div_end & sclk_q;
  assign last_bit = bit_end & (bit_q == 3'd7) & (byte_q == BLAST);

`ifdef BL_SPI_CHECKSUM_EN
  assign nxt_byte = (byte_q == ZLAST) ? csum_q : rd_data;
`else
  assign nxt_byte = rd_data;
`endif

  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) st_q <= ST_IDLE;
    else        st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_IDLE:  if (pend_q) st_d = ST_SETUP;
      ST_SETUP: if (div_end) st_d = ST_SHIFT;
      ST_SHIFT: if (last_bit) st_d = ST_HOLD;
      ST_HOLD:  if (div_end) st_d = ST_LATCH;
      ST_LATCH: if (lat_q == LAT_MAX) st_d = ST_IDLE;
      default:  st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    div_d   = '0;
    lat_d   = lat_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    sh_d    = sh_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    latch_d = latch_q;
    busy_d  = busy_q;
    fcnt_d  = fcnt_q;
`ifdef BL_SPI_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (st_q)
      ST_IDLE: begin
        lat_d  = '0;
        bit_d  = '0;
        byte_d = '0;
`ifdef BL_SPI_CHECKSUM_EN
        csum_d = '0;
`endif
        if (pend_q) begin
          cs_n_d = 1'b0;
          busy_d = 1'b1;
        end
      end
      ST_SETUP: begin
        div_d = div_end ? '0 : div_q + 1'b1;
        if (div_q == '0) begin
          sh_d   = rd_data[6:0];
          mosi_d = rd_data[7];
`ifdef BL_SPI_CHECKSUM_EN
          csum_d = csum_q ^ rd_data;
`endif
        end
      end
      ST_SHIFT: begin
        div_d = div_end ? '0 : div_q + 1'b1;
        if (div_end) sclk_d = ~sclk_q;
        if (last_bit) begin
          mosi_d = 1'b0;
        end else if (bit_end && bit_q == 3'd7) begin
          byte_d = byte_q + 1'b1;
          bit_d  = '0;
          sh_d   = nxt_byte[6:0];
          mosi_d = nxt_byte[7];
`ifdef BL_SPI_CHECKSUM_EN
          csum_d = csum_q ^ rd_data;
`endif
        end else if (bit_end) begin
          bit_d  = bit_q + 1'b1;
          sh_d   = {sh_q[5:0], 1'b0};
          mosi_d = sh_q[6];
        end
      end
      ST_HOLD: begin
        div_d = div_end ? '0 : div_q + 1'b1;
        if (div_end) begin
          cs_n_d  = 1'b1;
          latch_d = 1'b1;
        end
      end
      ST_LATCH: begin
        lat_d = lat_q + 1'b1;
        if (lat_q == LAT_MAX) begin
          lat_d   = '0;
          latch_d = 1'b0;
          busy_d  = 1'b0;
          fcnt_d  = fcnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q      <= 1'b0;
      wr_idx_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      pend_q    <= 1'b0;
      eshort_q  <= 1'b0;
      eovf_q    <= 1'b0;
      eovr_q    <= 1'b0;
      div_q     <= '0;
      lat_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      sh_q      <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      latch_q   <= 1'b0;
      busy_q    <= 1'b0;
      fcnt_q    <= '0;
`ifdef BL_SPI_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      vs_q      <= r_Vsync_0;
      wr_idx_q  <= wr_idx_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      pend_q    <= pend_d;
      eshort_q  <= eshort_d;
      eovf_q    <= eovf_d;
      eovr_q    <= eovr_d;
      div_q     <= div_d;
      lat_q     <= lat_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      sh_q      <= sh_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      latch_q   <= latch_d;
      busy_q    <= busy_d;
      fcnt_q    <= fcnt_d;
`ifdef BL_SPI_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign spi_sclk     = sclk_q;
  assign spi_mosi     = mosi_q;
  assign spi_cs_n     = cs_n_q;
  assign led_latch    = latch_q;
  assign tx_busy      = busy_q;
  assign err_short    = eshort_q;
  assign err_overflow = eovf_q;
  assign tx_overrun   = eovr_q;
  assign frame_cnt    = fcnt_q;

endmodule

// File: tb/tb_bl_zone_spi_tx.sv
// Bench for bl_zone_spi_tx: random zone data vs a frame-level model.
// Decodes the SPI stream and checks timing, errors and frame count.
module tb_bl_zone_spi_tx;
  import bl_pkg::*;

  localparam int CD = 4;
  localparam int LC = 8;
`ifdef BL_SPI_CHECKSUM_EN
  localparam int NB = ZONES + 1;
`else
  localparam int NB = ZONES;
`endif
  localparam int CS_LEN = CD + NB * 16 * CD + CD;
  localparam int TOTAL  = CS_LEN + LC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flag_done = 1'b0;
  logic        vs = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        spi_sclk, spi_mosi, spi_cs_n;
  logic        led_latch, tx_busy;
  logic        err_short, err_overflow, tx_overrun;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  bl_zone_spi_tx #(.CLK_DIV(CD), .LATCH_CYCLES(LC)) dut (
    .i_pix_clk       (clk),
    .rst_n           (rst_n),
    .flag_done       (flag_done),
    .buf_360_flatted (din),
    .r_Vsync_0       (vs),
    .spi_sclk        (spi_sclk),
    .spi_mosi        (spi_mosi),
    .spi_cs_n        (spi_cs_n),
    .led_latch       (led_latch),
    .tx_busy         (tx_busy),
    .err_short       (err_short),
    .err_overflow    (err_overflow),
    .tx_overrun      (tx_overrun),
    .frame_cnt       (frame_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Level monitors sampled on the falling edge.
  int cs_run = 0, cs_len = 0, lat_run = 0, lat_len = 0;
  int busy_run = 0, busy_len = 0;
  int cs_falls = 0, cs_fall_cyc = 0;
  int n_short = 0, n_ovf = 0, n_ovr = 0;
  logic cs_prev = 1'b1;

  always @(negedge clk) begin
    if (!spi_cs_n) cs_run++;
    else if (cs_run != 0) begin cs_len = cs_run; cs_run = 0; end
    if (led_latch) lat_run++;
    else if (lat_run != 0) begin lat_len = lat_run; lat_run = 0; end
    if (tx_busy) busy_run++;
    else if (busy_run != 0) begin busy_len = busy_run; busy_run = 0; end
    if (cs_prev && !spi_cs_n) begin cs_falls++; cs_fall_cyc = cyc; end
    cs_prev = spi_cs_n;
    n_short += int'(err_short);
    n_ovf   += int'(err_overflow);
    n_ovr   += int'(tx_overrun);
  end

  // SPI receiver: mode 0, sample on rising SCLK, frame ends on CS rise.
  logic [7:0] rx_sh = 8'h00;
  int rx_bits = 0;
  int frames_seen = 0;
  logic [7:0] rx_q[$];
  logic [7:0] rx_frame[$];

  always @(posedge spi_sclk or posedge spi_cs_n or negedge rst_n) begin
    if (!rst_n) begin
      rx_q.delete();
      rx_bits = 0;
    end else if (spi_cs_n) begin
      rx_frame = rx_q;
      rx_q.delete();
      rx_bits = 0;
      frames_seen++;
    end else begin
      rx_sh = {rx_sh[6:0], spi_mosi};
      rx_bits++;
      if (rx_bits == 8) begin
        rx_q.push_back(rx_sh);
        rx_bits = 0;
      end
    end
  end

  // Frame-level reference model.
  logic [7:0] m_buf[$];
  logic [7:0] m_exp[$];
  int m_cnt = 0, m_acc = 0, m_frames = 0;
  int m_short = 0, m_ovf = 0, m_ovr = 0;
  bit m_any = 1'b0;

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    flag_done = 1'b1;
    din = b;
    if (m_cnt < ZONES) begin
      m_buf.push_back(b);
      m_cnt++;
    end else begin
      m_ovf++;
    end
    @(negedge clk);
    flag_done = 1'b0;
    din = 8'($urandom);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic boundary();
    int c;
    logic [7:0] x;
    @(negedge clk);
    vs = 1'b1;
    c = cyc + 1;
    if (m_cnt != ZONES) begin
      m_short++;
    end else if (m_any && c < m_acc + 2 + TOTAL) begin
      m_ovr++;
    end else begin
      m_exp = m_buf;
`ifdef BL_SPI_CHECKSUM_EN
      x = 8'h00;
      foreach (m_buf[i]) x ^= m_buf[i];
      m_exp.push_back(x);
`else
      x = 8'h00;
`endif
      m_acc = c;
      m_any = 1'b1;
      m_frames++;
    end
    m_buf.delete();
    m_cnt = 0;
    repeat (3) @(negedge clk);
    vs = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_frames(input int target, input string tag);
    int t = 0;
    while (frames_seen < target && t < TOTAL + 5000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(frames_seen >= target), 1);
  endtask

  task automatic chk_frame(input string tag);
    logic [7:0] got;
    chk({tag, "_len"}, rx_frame.size(), m_exp.size());
    for (int i = 0; i < m_exp.size(); i++) begin
      got = (i < rx_frame.size()) ? rx_frame[i] : 8'hxx;
      chk($sformatf("%s[%0d]", tag, i), got, m_exp[i]);
    end
  endtask

  initial begin
    int f, fs, t;
    logic [7:0] b;
    repeat (5) @(negedge clk);
    chk("rst_cs_n", spi_cs_n, 1);
    chk("rst_sclk", spi_sclk, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_latch", led_latch, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_fcnt", frame_cnt, 0);
    rst_n = 1'b1;

    f = cs_falls;
    repeat (1000) @(negedge clk);
    chk("idle_cs", cs_falls - f, 0);
    chk("idle_busy", tx_busy, 0);

    for (int i = 0; i < ZONES; i++) put(8'(i));
    fs = frames_seen;
    boundary();
    wait_frames(fs + 1, "full_done");
    repeat (20) @(negedge clk);
    chk("full_cs_lat", cs_fall_cyc - m_acc, 1);
    chk_frame("full");
    chk("full_cs_len", cs_len, CS_LEN);
    chk("full_latch", lat_len, LC);
    chk("full_busy", busy_len, TOTAL);
    chk("full_fcnt", frame_cnt, m_frames);

    f = cs_falls;
    for (int i = 0; i < ZONES - 1; i++) put(8'($urandom));
    boundary();
    repeat (50) @(negedge clk);
    chk("short_err", n_short, m_short);
    chk("short_cs", cs_falls - f, 0);
    chk("short_fcnt", frame_cnt, m_frames);

    for (int i = 0; i < ZONES; i++) begin
`ifdef BL_SPI_CHECKSUM_EN
      b = (i == 0) ? 8'h5A : 8'hA5;
`else
      b = 8'($urandom);
`endif
      put(b);
    end
    chk("ovf_none", n_ovf, m_ovf);
    put(8'($urandom));
    repeat (2) @(negedge clk);
    chk("ovf_pulse", n_ovf, m_ovf);
    f = cs_falls;
    fs = frames_seen;
    boundary();
    t = 0;
    while (!tx_busy && t < 100) begin @(negedge clk); t++; end
    chk("ovf_start", tx_busy, 1);
    for (int i = 0; i < ZONES; i++) put(8'($urandom));
    boundary();
    repeat (5) @(negedge clk);
    chk("ovr_pulse", n_ovr, m_ovr);
    wait_frames(fs + 1, "ovf_done");
    repeat (20) @(negedge clk);
    chk_frame("ovf");
`ifdef BL_SPI_CHECKSUM_EN
    b = (rx_frame.size() > ZONES) ? rx_frame[ZONES] : 8'h00;
    chk("csum_byte", b, 8'hFF);
`endif
    chk("ovr_fcnt", frame_cnt, m_frames);
    repeat (100) @(negedge clk);
    chk("ovr_idle", tx_busy, 0);
    chk("ovr_one_tx", cs_falls - f, 1);

    for (int i = 0; i < ZONES; i++) put(8'($urandom));
    boundary();
    t = 0;
    while (rx_q.size() < 100 && t < 200 * 16 * CD) begin
      @(negedge clk);
      t++;
    end
    chk("mid_reach", 32'(rx_q.size() >= 100), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_cs_n", spi_cs_n, 1);
    chk("mid_sclk", spi_sclk, 0);
    chk("mid_busy", tx_busy, 0);
    chk("mid_fcnt", frame_cnt, 0);
    m_buf.delete();
    m_cnt = 0;
    m_frames = 0;
    m_any = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    f = cs_falls;
    repeat (300) @(negedge clk);
    chk("mid_no_tx", cs_falls - f, 0);
    chk("mid_fcnt2", frame_cnt, m_frames);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
